// File: rtl/dm_pkg.sv
// Shared types and constants for the latency-modelling data-memory responder.
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 15;
    localparam int unsigned WORD_W  = 32;

endpackage

// File: rtl/dm_storage_ram.sv
// Synchronous single-port word store with registered read data; contents are
// never reset.
module dm_storage_ram
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [WORD_W-1:0]          wdata,
    output logic [WORD_W-1:0]          rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dm_latency_responder.sv
// Data-memory responder that accepts one load/store, holds the pipeline for
// LATENCY busy cycles, then signals completion for a single cycle.
module dm_latency_responder
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       MemAddr,
    input  logic [31:0]       MemWriteData,
    output logic [31:0]       MemReadData,
    output logic              MemStall,
    output logic              MemReady,
    output logic              MemErr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(LAT_MAX + 1);
    localparam logic [CW-1:0] LAT_LOAD = CW'(LATENCY);

    state_t              state;
    logic [CW-1:0]       count;
    logic [AW-1:0]       addrQ;
    logic [WORD_W-1:0]   dataQ;
    logic                writeQ;

    logic                req;
    logic [AW-1:0]       reqIdx;
    logic [AW-1:0]       ramAddr;
    logic                ramWe;
    logic [WORD_W-1:0]   ramRdata;
    logic                unusedAddrBits;

    assign req            = MemRead | MemWrite;
    assign reqIdx         = MemAddr[AW+1:2];
    assign unusedAddrBits = ^{MemAddr[31:AW+2], MemAddr[1:0]};

    // The RAM reads the live request address while idle so its registered
    // output already holds the target word once BUSY begins.
    assign ramAddr = (state == IDLE) ? reqIdx : addrQ;
    assign ramWe   = (state == BUSY) && (count == CW'(1)) && writeQ && !rst;

    dm_storage_ram #(
        .DEPTH (DEPTH)
    ) uStorage (
        .clk   (clk),
        .we    (ramWe),
        .addr  (ramAddr),
        .wdata (dataQ),
        .rdata (ramRdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            MemReadData <= '0;
            MemErr      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addrQ  <= reqIdx;
                        dataQ  <= MemWriteData;
                        writeQ <= MemWrite;
                        count  <= LAT_LOAD;
                        state  <= BUSY;
                        if (MemRead && MemWrite) begin
                            MemErr <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        if (!writeQ) begin
                            MemReadData <= ramRdata;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        MemStall = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    MemStall = req;
                BUSY:    MemStall = 1'b1;
                default: MemStall = 1'b0;
            endcase
        end
    end

    assign MemReady = (state == RESP) && !rst;

endmodule

// File: tb/tb_dm_latency_responder.sv
// Drives one shared request stream into responders built with LATENCY 1..4 and
// checks every output, every cycle, against a timing-rule model of each.
module tb_dm_latency_responder;

    localparam int NI    = 4;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [31:0] memAddr = '0;
    logic [31:0] memWriteData = '0;

    logic [31:0] rdData [NI];
    logic        stall  [NI];
    logic        ready  [NI];
    logic        err    [NI];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gDut
        dm_latency_responder #(
            .DEPTH   (DEPTH),
            .LATENCY (g + 1)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .MemRead      (memRead),
            .MemWrite     (memWrite),
            .MemAddr      (memAddr),
            .MemWriteData (memWriteData),
            .MemReadData  (rdData[g]),
            .MemStall     (stall[g]),
            .MemReady     (ready[g]),
            .MemErr       (err[g])
        );
    end

    // Model: an access accepted at cycle s stalls through s+L, completes
    // (commit or read capture) on the edge ending s+L, and responds in s+L+1.
    bit          active  [NI];
    int          start   [NI];
    bit          mWrite  [NI];
    int          mIdx    [NI];
    logic [31:0] mData   [NI];
    logic [31:0] mRd     [NI];
    bit          mErr    [NI];
    logic [31:0] mem     [NI][DEPTH];
    int          readyCnt[NI];
    int          cyc   = 0;
    bit          armed = 1'b0;

    task automatic check(input string nm, input int inst, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s [LATENCY=%0d] cycle %0d: got %h, expected %h",
                     nm, inst + 1, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        int  lat;
        int  ph;
        bit  req;
        bit  eStall;
        bit  eReady;
        req = memRead | memWrite;
        for (int i = 0; i < NI; i++) begin
            lat = i + 1;
            ph  = cyc - start[i];
            if (armed) begin
                eStall = !rst && (active[i] ? (ph <= lat) : req);
                eReady = !rst && active[i] && (ph == lat + 1);
                check("MemStall",    i, 32'(stall[i]), 32'(eStall));
                check("MemReady",    i, 32'(ready[i]), 32'(eReady));
                check("MemReadData", i, rdData[i],     mRd[i]);
                check("MemErr",      i, 32'(err[i]),   32'(mErr[i]));
                if (ready[i] === 1'b1) readyCnt[i]++;
            end
            if (rst) begin
                active[i] = 1'b0;
                mRd[i]    = '0;
                mErr[i]   = 1'b0;
            end else if (active[i]) begin
                if (ph == lat) begin
                    if (mWrite[i]) mem[i][mIdx[i]] = mData[i];
                    else           mRd[i] = mem[i][mIdx[i]];
                end
                if (ph == lat + 1) active[i] = 1'b0;
            end else if (req) begin
                active[i] = 1'b1;
                start[i]  = cyc;
                mWrite[i] = memWrite;
                mIdx[i]   = int'((memAddr >> 2) % DEPTH);
                mData[i]  = memWriteData;
                if (memRead && memWrite) mErr[i] = 1'b1;
            end
        end
        if (rst) armed = 1'b1;
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d);
        memRead      = rd;
        memWrite     = wr;
        memAddr      = a;
        memWriteData = d;
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input int hold);
        drive(rd, wr, a, d);
        tick(hold);
        drive(1'b0, 1'b0, '0, '0);
        tick(7);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        check("reset MemReadData", 1, rdData[1], 32'h0);
        check("reset MemErr",      1, 32'(err[1]),   32'h0);
        check("reset MemReady",    1, 32'(ready[1]), 32'h0);
        tick(1);

        access(1'b0, 1'b1, 32'h14, 32'hDEADBEEF, 1);
        access(1'b0, 1'b1, 32'h0C, 32'h0BADF00D, 1);

        // Single load at LATENCY=2: stall T..T+2, respond at T+3.
        drive(1'b1, 1'b0, 32'h14, '0);
        @(negedge clk);
        check("load stall T", 1, 32'(stall[1]), 32'h1);
        tick(1);
        drive(1'b0, 1'b0, '0, '0);
        tick(1);
        @(negedge clk);
        check("load stall T+2", 1, 32'(stall[1]), 32'h1);
        tick(1);
        @(negedge clk);
        check("load ready T+3", 1, 32'(ready[1]), 32'h1);
        check("load data T+3",  1, rdData[1],     32'hDEADBEEF);
        check("load stall T+3", 1, 32'(stall[1]), 32'h0);
        tick(7);

        // Store then load, requests held through RESP at LATENCY=1.
        rc = readyCnt[0];
        drive(1'b0, 1'b1, 32'h40, 32'h12345678);
        tick(3);
        drive(1'b1, 1'b0, 32'h40, '0);
        tick(3);
        drive(1'b0, 1'b0, '0, '0);
        tick(7);
        check("store/load pulses", 0, 32'(readyCnt[0] - rc), 32'd2);
        check("store/load data",   0, rdData[0], 32'h12345678);

        // Read held for 10 cycles at LATENCY=3: responses at +4 and +9 only.
        rc = readyCnt[2];
        drive(1'b1, 1'b0, 32'h14, '0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 4 || k == 9) check("held ready", 2, 32'(ready[2]), 32'h1);
            tick(1);
        end
        drive(1'b0, 1'b0, '0, '0);
        tick(7);
        check("held pulses", 2, 32'(readyCnt[2] - rc), 32'd2);

        // Address wrap and ignored byte offset.
        access(1'b0, 1'b1, 32'h0000_0403, 32'hA5A5A5A5, 1);
        access(1'b1, 1'b0, 32'h0000_0000, '0, 1);
        check("wrap data", 1, rdData[1], 32'hA5A5A5A5);

        // Read+write conflict behaves as a write and sets the sticky error.
        access(1'b1, 1'b1, 32'h8, 32'h77, 1);
        check("conflict err",  1, 32'(err[1]), 32'h1);
        check("conflict data", 1, rdData[1],   32'hA5A5A5A5);
        access(1'b1, 1'b0, 32'h8, '0, 1);
        check("conflict readback", 1, rdData[1],   32'h77);
        check("err sticky",        1, 32'(err[1]), 32'h1);

        // Reset in the 2nd BUSY cycle of a LATENCY=4 write discards it.
        drive(1'b0, 1'b1, 32'hC, 32'hFFFF0000);
        tick(1);
        drive(1'b0, 1'b0, '0, '0);
        tick(1);
        rst = 1'b1;
        @(negedge clk);
        check("rst stall",  3, 32'(stall[3]), 32'h0);
        check("rst ready",  3, 32'(ready[3]), 32'h0);
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("post-rst stall", 3, 32'(stall[3]), 32'h0);
        check("post-rst ready", 3, 32'(ready[3]), 32'h0);
        check("post-rst data",  3, rdData[3],     32'h0);
        tick(7);
        access(1'b1, 1'b0, 32'hC, '0, 1);
        check("discarded write", 3, rdData[3],   32'h0BADF00D);
        check("committed write", 0, rdData[0],   32'hFFFF0000);
        check("err cleared",     3, 32'(err[3]), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
